// File: rtl/if_id_stage_register.sv
// IF/ID pipeline register for the pipelined MIPS datapath.
// Latches the fetched instruction and PC+4 for the decode stage. A stall
// holds the slot and a flush replaces it with a NOP bubble. The register
// also keeps fetch sequence tags, stall and flush tallies, and a sticky
// watchdog that flags an overly long stall.

module if_id_stage_register #(
   parameter int DATA_W    = 32,
   parameter int SEQ_W     = 8,
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] Instruction_in,
   input  logic [DATA_W-1:0] PCPlus4_in,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] Instruction_out,
   output logic [DATA_W-1:0] PCPlus4_out,
   output logic              Valid_out,
   output logic [SEQ_W-1:0]  SeqNum_out,
   output logic [1:0]        State_out,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  FlushCount,
   output logic              StallTimeout
);

   // The run counter only needs enough width to count up to MAX_STALL.
   localparam int RUN_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

   // The action taken on the most recent edge; the encoding is the one
   // reported on State_out.
   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_LOAD   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_BUBBLE = 2'd3
   } stage_state_t;

   // The declaration initialisers give every register a zero value from
   // time zero, so no output is X before the first Reset.
   stage_state_t      r_state        = ST_RESET;
   logic [DATA_W-1:0] r_instruction  = '0;
   logic [DATA_W-1:0] r_pcPlus4      = '0;
   logic              r_valid        = 1'b0;
   logic [SEQ_W-1:0]  r_seqNum       = '0;
   logic [SEQ_W-1:0]  r_seqCounter   = '0;
   logic [CNT_W-1:0]  r_stallCount   = '0;
   logic [CNT_W-1:0]  r_flushCount   = '0;
   logic [RUN_W-1:0]  r_runCount     = '0;
   logic              r_stallTimeout = 1'b0;

   stage_state_t      w_nextState;
   logic [CNT_W-1:0]  w_stallCountInc;
   logic [CNT_W-1:0]  w_flushCountInc;
   logic [RUN_W-1:0]  w_runCountInc;

   // These are the saturating increments of the counters. The sequence
   // counter is not among them because it wraps.
   assign w_stallCountInc = (r_stallCount == CNT_MAX) ? r_stallCount : r_stallCount + CNT_ONE;
   assign w_flushCountInc = (r_flushCount == CNT_MAX) ? r_flushCount : r_flushCount + CNT_ONE;
   assign w_runCountInc   = (r_runCount == RUN_MAX) ? r_runCount : r_runCount + RUN_ONE;

   // Select this edge's action. Reset wins, then flush, then stall; the
   // remaining case is a normal load.
   always_comb begin
      w_nextState = ST_LOAD;
      if (Reset) begin
         w_nextState = ST_RESET;
      end else if (flush) begin
         w_nextState = ST_BUBBLE;
      end else if (stall) begin
         w_nextState = ST_HOLD;
      end
   end

   // Apply the selected action to the slot contents and to the bookkeeping
   // counters.
   always_ff @(posedge Clk) begin
      r_state <= w_nextState;
      case (w_nextState)
         ST_RESET: begin
            r_instruction  <= '0;
            r_pcPlus4      <= '0;
            r_valid        <= 1'b0;
            r_seqNum       <= '0;
            r_seqCounter   <= '0;
            r_stallCount   <= '0;
            r_flushCount   <= '0;
            r_runCount     <= '0;
            r_stallTimeout <= 1'b0;
         end
         ST_BUBBLE: begin
            r_instruction <= '0;
            r_pcPlus4     <= '0;
            r_valid       <= 1'b0;
            r_flushCount  <= w_flushCountInc;
            r_runCount    <= '0;
         end
         ST_HOLD: begin
            r_stallCount <= w_stallCountInc;
            r_runCount   <= w_runCountInc;
            if (w_runCountInc == RUN_MAX) begin
               r_stallTimeout <= 1'b1;
            end
         end
         default: begin
            r_instruction <= Instruction_in;
            r_pcPlus4     <= PCPlus4_in;
            r_valid       <= 1'b1;
            r_seqNum      <= r_seqCounter;
            r_seqCounter  <= r_seqCounter + SEQ_ONE;
            r_runCount    <= '0;
         end
      endcase
   end

   assign Instruction_out = r_instruction;
   assign PCPlus4_out     = r_pcPlus4;
   assign Valid_out       = r_valid;
   assign SeqNum_out      = r_seqNum;
   assign State_out       = r_state;
   assign StallCount      = r_stallCount;
   assign FlushCount      = r_flushCount;
   assign StallTimeout    = r_stallTimeout;

endmodule

// File: tb/tb_if_id_stage_register.sv
// Testbench for if_id_stage_register.
// Directed sequences and random traffic are checked against a behavioural
// model of the slot. A second instance with narrow counters exercises
// counter saturation.

module tb_if_id_stage_register;

   localparam int DATA_W    = 32;
   localparam int SEQ_W     = 8;
   localparam int CNT_W     = 16;
   localparam int MAX_STALL = 16;
   localparam int SMALL_W   = 3;

   logic              Clk = 1'b0;
   logic              Reset = 1'b0;
   logic [DATA_W-1:0] Instruction_in = '0;
   logic [DATA_W-1:0] PCPlus4_in = '0;
   logic              stall = 1'b0;
   logic              flush = 1'b0;

   logic [DATA_W-1:0] Instruction_out;
   logic [DATA_W-1:0] PCPlus4_out;
   logic              Valid_out;
   logic [SEQ_W-1:0]  SeqNum_out;
   logic [1:0]        State_out;
   logic [CNT_W-1:0]  StallCount;
   logic [CNT_W-1:0]  FlushCount;
   logic              StallTimeout;

   logic [DATA_W-1:0] smallInstruction;
   logic [DATA_W-1:0] smallPcPlus4;
   logic              smallValid;
   logic [SEQ_W-1:0]  smallSeqNum;
   logic [1:0]        smallState;
   logic [SMALL_W-1:0] smallStallCount;
   logic [SMALL_W-1:0] smallFlushCount;
   logic              smallTimeout;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the slot.
   logic [DATA_W-1:0] mInstr = '0;
   logic [DATA_W-1:0] mPc = '0;
   int  mValid = 0;
   int  mSeq = 0;
   int  mNextTag = 0;
   int  mState = 0;
   int  mStallTotal = 0;
   int  mFlushTotal = 0;
   int  mStallRun = 0;
   int  mTimeout = 0;

   if_id_stage_register #(
      .DATA_W(DATA_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .Instruction_in(Instruction_in), .PCPlus4_in(PCPlus4_in),
      .stall(stall), .flush(flush),
      .Instruction_out(Instruction_out), .PCPlus4_out(PCPlus4_out),
      .Valid_out(Valid_out), .SeqNum_out(SeqNum_out), .State_out(State_out),
      .StallCount(StallCount), .FlushCount(FlushCount),
      .StallTimeout(StallTimeout)
   );

   if_id_stage_register #(
      .DATA_W(DATA_W), .SEQ_W(SEQ_W), .CNT_W(SMALL_W), .MAX_STALL(MAX_STALL)
   ) dutSmall (
      .Clk(Clk), .Reset(Reset),
      .Instruction_in(Instruction_in), .PCPlus4_in(PCPlus4_in),
      .stall(stall), .flush(flush),
      .Instruction_out(smallInstruction), .PCPlus4_out(smallPcPlus4),
      .Valid_out(smallValid), .SeqNum_out(smallSeqNum), .State_out(smallState),
      .StallCount(smallStallCount), .FlushCount(smallFlushCount),
      .StallTimeout(smallTimeout)
   );

   // Free-running clock with a 10 ns period.
   always #5 Clk = ~Clk;

   function automatic int satTo(input int total, input int width);
      int limit;
      limit = (1 << width) - 1;
      return (total > limit) ? limit : total;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("instr", 64'(Instruction_out), 64'(mInstr));
      checkOutput("pc4", 64'(PCPlus4_out), 64'(mPc));
      checkOutput("valid", 64'(Valid_out), 64'(mValid));
      checkOutput("seq", 64'(SeqNum_out), 64'(mSeq));
      checkOutput("state", 64'(State_out), 64'(mState));
      checkOutput("stallCnt", 64'(StallCount), 64'(satTo(mStallTotal, CNT_W)));
      checkOutput("flushCnt", 64'(FlushCount), 64'(satTo(mFlushTotal, CNT_W)));
      checkOutput("timeout", 64'(StallTimeout), 64'(mTimeout));
      checkOutput("smallStallCnt", 64'(smallStallCount), 64'(satTo(mStallTotal, SMALL_W)));
      checkOutput("smallFlushCnt", 64'(smallFlushCount), 64'(satTo(mFlushTotal, SMALL_W)));
      checkOutput("smallInstr", 64'(smallInstruction), 64'(mInstr));
      checkOutput("smallTimeout", 64'(smallTimeout), 64'(mTimeout));
   endtask

   // Update the model with the action implied by one edge's inputs. Reset
   // wins, then flush, then stall; otherwise the inputs are loaded.
   task automatic modelEdge(input logic rst, input logic fl, input logic st,
                            input logic [DATA_W-1:0] instr,
                            input logic [DATA_W-1:0] pc);
      if (rst) begin
         mInstr = '0; mPc = '0; mValid = 0; mSeq = 0; mNextTag = 0;
         mState = 0; mStallTotal = 0; mFlushTotal = 0; mStallRun = 0;
         mTimeout = 0;
      end else if (fl) begin
         mInstr = '0; mPc = '0; mValid = 0; mState = 3;
         mFlushTotal++; mStallRun = 0;
      end else if (st) begin
         mState = 2;
         mStallTotal++;
         if (mStallRun < MAX_STALL) mStallRun++;
         if (mStallRun == MAX_STALL) mTimeout = 1;
      end else begin
         mInstr = instr; mPc = pc; mValid = 1; mState = 1;
         mSeq = mNextTag;
         mNextTag = (mNextTag + 1) % (1 << SEQ_W);
         mStallRun = 0;
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare.
   task automatic applyStimulus(input logic rst, input logic fl, input logic st,
                                input logic [DATA_W-1:0] instr,
                                input logic [DATA_W-1:0] pc);
      @(negedge Clk);
      Reset = rst; flush = fl; stall = st;
      Instruction_in = instr; PCPlus4_in = pc;
      @(posedge Clk);
      modelEdge(rst, fl, st, instr, pc);
      #1;
      checkAll();
   endtask

   initial begin
      logic [DATA_W-1:0] progWords [3];
      int burst;
      int roll;

      progWords[0] = 32'h8C010004;
      progWords[1] = 32'h00221820;
      progWords[2] = 32'hAC030008;

      // All outputs are zero before any clock edge.
      #2;
      checkAll();

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

      $display("[TB] three loads");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, progWords[i], DATA_W'(4 * (i + 1)));
      end

      $display("[TB] load then stall three cycles");
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, progWords[0], 32'd4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, progWords[1], 32'd8);

      $display("[TB] flush with stall");
      applyStimulus(1'b0, 1'b1, 1'b1, $urandom, $urandom);
      applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom);
      applyStimulus(1'b0, 1'b0, 1'b0, progWords[2], 32'd12);

      $display("[TB] stall watchdog");
      for (int i = 0; i < MAX_STALL + 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, $urandom, $urandom);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

      $display("[TB] sequence wrap");
      for (int i = 0; i < 258; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, $urandom, DATA_W'(4 * (i + 1)));
      end

      $display("[TB] reset during stall");
      applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom);
      applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom);
      applyStimulus(1'b1, 1'b0, 1'b1, $urandom, $urandom);
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom, $urandom);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         roll = int'($urandom_range(0, 99));
         if (roll < 1) begin
            applyStimulus(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom, $urandom);
         end else if (roll < 4) begin
            burst = int'($urandom_range(MAX_STALL - 3, MAX_STALL + 3));
            for (int j = 0; j < burst; j++) begin
               applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom);
            end
         end else if (roll < 14) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom);
         end else if (roll < 40) begin
            applyStimulus(1'b0, 1'b0, 1'b1, $urandom, $urandom);
         end else begin
            applyStimulus(1'b0, 1'b0, 1'b0, $urandom, $urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
